div_ctrl: RTL and testbench

- Multi-cycle 32-bit divider sequencer for the EX stage; serves DIV/DIVU issued by the ID stage.
- Latches operands, runs one radix-2 restoring step per cycle and applies sign correction.
- Returns {remainder, quotient} for the HI/LO write path.
- EX holds start_i and stalls the pipeline until ready_o is high.

---
 rtl/div_ctrl.sv | 139 +++++++++++++
 tb/tb_div_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider sequencer for DIV/DIVU, result {rem, quot}.
// Optional: define DIV_ZERO_SKIP_EN to finish zero-divisor requests early via BYZERO.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   dividend_mag, divisor_mag;
  logic [DATA_W-1:0]   quot_mag, rem_mag;
  logic [DATA_W:0]     diff;

  assign dividend_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign divisor_mag  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Quotient bits collect in the low half; the partial remainder sits one bit above it.
  assign quot_mag = work_q[DATA_W-1:0];
  assign rem_mag  = work_q[2*DATA_W:DATA_W+1];
  assign diff     = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          neg_quot_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d  = signed_div_i & opdata1_i[DATA_W-1];
          divisor_d  = divisor_mag;
          cnt_d      = '0;
          work_d     = {{DATA_W{1'b0}}, dividend_mag, 1'b0};
          state_d    = ON;
`ifdef DIV_ZERO_SKIP_EN
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end
`endif
        end
      end

      BYZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = END;
        end
      end

      ON: begin
        if (annul_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          result_d = {(neg_rem_q  ? -rem_mag  : rem_mag),
                      (neg_quot_q ? -quot_mag : quot_mag)};
          ready_d  = 1'b1;
          state_d  = END;
        end else begin
          if (!diff[DATA_W]) begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          end else begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      END: begin
        if (annul_i || !start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        result_d = '0;
        ready_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: vector table, hand-written corner sequences and random ops vs an arithmetic model.
module tb_div_ctrl;
  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int passed_checks = 0;
  int total_checks  = 0;

  localparam int FULL_LAT = 33;
`ifdef DIV_ZERO_SKIP_EN
  localparam logic [63:0] ZERO_RES = 64'd0;
  localparam int          ZERO_LAT = 1;
`else
  localparam logic [63:0] ZERO_RES = {32'd5, 32'hFFFF_FFFF};
  localparam int          ZERO_LAT = FULL_LAT;
`endif

  typedef struct {
    string       name;
    logic        sdiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  div_ctrl #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference divide from magnitudes, plain / and %, then sign fix-up.
  function automatic logic [63:0] model_result(input logic sdiv, input logic [31:0] a,
                                                input logic [31:0] b);
    logic        an, bn;
    logic [31:0] am, bm, q, r;
    an = sdiv && a[31];
    bn = sdiv && b[31];
    am = an ? -a : a;
    bm = bn ? -b : b;
`ifdef DIV_ZERO_SKIP_EN
    if (b == 32'd0) return 64'd0;
`endif
    if (bm == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = am;
    end else begin
      q = am / bm;
      r = am % bm;
    end
    if (an != bn) q = -q;
    if (an) r = -r;
    return {r, q};
  endfunction

  function automatic int model_latency(input logic [31:0] b);
    return (b == 32'd0) ? ZERO_LAT : FULL_LAT;
  endfunction

  function automatic logic [63:0] status();
    return {62'd0, ready_o, busy_o};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passed_checks++;
  endtask

  // Raise start, then wait (bounded) for ready while scrambling the operands.
  task automatic applyStimulus(input logic sdiv, input logic [31:0] a, input logic [31:0] b,
                               output int cycles, output logic [63:0] res);
    signed_div_i = sdiv;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk); #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sdiv;
    cycles = 0;
    while (!ready_o && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    res = result_o;
  endtask

  task automatic run_check(input string name, input logic sdiv, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int          cyc;
    logic [63:0] res;
    applyStimulus(sdiv, a, b, cyc, res);
    checkOutput({name, "_result"}, res, exp_res);
    checkOutput({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    start_i = 1'b0;
    @(posedge clk); #1;
    checkOutput({name, "_drop_status"}, status(), 64'd0);
    checkOutput({name, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    int          cyc;
    logic [63:0] res;
    logic        seen;
    logic        sd;
    logic [31:0] a, b;

    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},                  FULL_LAT};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD},   FULL_LAT};
    vecs[2] = '{"div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000},           FULL_LAT};
    vecs[3] = '{"divu_5_0",     1'b0, 32'd5,         32'd0,         ZERO_RES,                         ZERO_LAT};
    vecs[4] = '{"divu_9_3",     1'b0, 32'd9,         32'd3,         {32'd0, 32'd3},                   FULL_LAT};
    vecs[5] = '{"div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},           FULL_LAT};
    vecs[6] = '{"divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF},           FULL_LAT};
    vecs[7] = '{"div_m8_m3",    1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2},           FULL_LAT};

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #12;
    checkOutput("reset_status", status(), 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_status", status(), 64'd0);

    foreach (vecs[i])
      run_check(vecs[i].name, vecs[i].sdiv, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);

    // Annul 10 cycles into ON; annul must also win over a still-high start.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("on_status", status(), 64'd1);
    repeat (9) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("annul_on_status", status(), 64'd0);
    @(posedge clk); #1;
    checkOutput("annul_priority_status", status(), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    checkOutput("annul_no_ready", 64'(seen), 64'd0);
    run_check("after_annul_divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, FULL_LAT);

    // Annul while the result is being held.
    applyStimulus(1'b0, 32'd50, 32'd6, cyc, res);
    checkOutput("end_annul_pre_result", res, {32'd2, 32'd8});
    annul_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("end_annul_status", status(), 64'd0);
    checkOutput("end_annul_result", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset between edges in the middle of ON.
    signed_div_i = 1'b1; opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_status", status(), 64'd0);
    checkOutput("async_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_check("post_reset_divu", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, FULL_LAT);

    for (int k = 0; k < 16; k++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 20));
        1:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_check($sformatf("rand%0d", k), sd, a, b, model_result(sd, a, b), model_latency(b));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
